tpuv2_ctrl: RTL

Parametrised bus front-end and sequencer for the second-generation TPU. Decodes a single-cycle memory-mapped bus into load/unload controls for memA, memB and systolic_array, and runs the multiply sequence from a command register. Adds two things the first generation lacks: an optional clear-before-multiply pass and a busy/status register. Sits between the host bus and the three datapath blocks in the TPU top.

---
 rtl/tpuv2_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tpuv2_ctrl.sv
// Bus front-end and multiply sequencer for the second-generation TPU.
// Optional PERF cycle counter is built when TPU_PERF_CNT_EN is defined.
module tpuv2_ctrl #(
   parameter int BITS_AB = 8,
   parameter int BITS_C  = 16,
   parameter int DIM     = 8,
   parameter int ADDRW   = 16,
   parameter int DATAW   = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    r_w,
   input  logic [ADDRW-1:0]        addr,
   input  logic [DATAW-1:0]        dataIn,
   output logic [DATAW-1:0]        dataOut,
   output logic                    busy,
   output logic                    enA,
   output logic                    WrEnA,
   output logic                    enB,
   output logic [$clog2(DIM)-1:0]  Arow,
   output logic                    enS,
   output logic                    WrEnS,
   output logic [$clog2(DIM)-1:0]  Crow,
   output logic [DIM*BITS_C-1:0]   Cin,
   input  logic [DIM*BITS_C-1:0]   Cout
);

   localparam int CW   = (DIM*BITS_C + DATAW - 1) / DATAW;
   localparam int ROWW = $clog2(DIM);
   localparam int BPW  = DATAW / 8;
   localparam int BSH  = $clog2(BPW);
   localparam int MULN = 3*DIM - 2;
   localparam int CNTW = $clog2(MULN + 1);

   typedef enum logic [1:0] {IDLE, CLEAR, MUL} stateT;

   stateT                   state;
   logic [CNTW-1:0]         cnt;
   logic [(CW-1)*DATAW-1:0] cBuf;
   logic [CW*DATAW-1:0]     coutPad;
   logic [CW*DATAW-1:0]     cFull;
   logic [31:0]             perfVal;

   logic [ADDRW-1:0] aOff, bOff, cOff, cWord, cSel;
   logic [ROWW-1:0]  aRow, cRow, mulRow;
   logic             aligned, aHit, bHit, cHit, cmdHit, statusHit, perfHit;
   logic             wrReq, rdReq, cLast, cCommit;
   logic [DATAW-1:0] rdData;

   // Address decode: an address below a window base wraps high and misses it.
   always_comb begin
      aOff      = addr - ADDRW'('h0100);
      bOff      = addr - ADDRW'('h0200);
      cOff      = addr - ADDRW'('h0300);
      aligned   = (addr[BSH-1:0] == '0);
      aHit      = aligned && (aOff < ADDRW'(DIM*BPW));
      bHit      = aligned && (bOff < ADDRW'(DIM*BPW));
      cHit      = aligned && (cOff < ADDRW'(DIM*CW*BPW));
      aRow      = aOff[BSH +: ROWW];
      cWord     = cOff >> BSH;
      cSel      = cWord % ADDRW'(CW);
      cRow      = ROWW'(cWord / ADDRW'(CW));
      cmdHit    = (addr == ADDRW'('h0400));
      statusHit = (addr == ADDRW'('h0408));
      perfHit   = (addr == ADDRW'('h0410));
   end

   assign busy    = (state != IDLE);
   assign wrReq   = en && r_w && !busy;
   assign rdReq   = en && !r_w;
   assign cLast   = (cSel == ADDRW'(CW-1));
   assign cCommit = wrReq && cHit && cLast;
   assign cFull   = {dataIn, cBuf};
   assign mulRow  = (cnt < CNTW'(DIM)) ? cnt[ROWW-1:0] : ROWW'(DIM-1);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      coutPad                 = '0;
      coutPad[DIM*BITS_C-1:0] = Cout;
      enA   = (state == MUL);
      enS   = (state == MUL);
      enB   = (state == MUL) || (wrReq && bHit);
      WrEnA = wrReq && aHit;
      WrEnS = (state == CLEAR) || cCommit;
      Arow  = '0;
      if (state == MUL)       Arow = mulRow;
      else if (wrReq && aHit) Arow = aRow;
      Crow  = '0;
      if (state == CLEAR)            Crow = cnt[ROWW-1:0];
      else if (en && !busy && cHit)  Crow = cRow;
      Cin   = '0;
      if (cCommit) Cin = cFull[DIM*BITS_C-1:0];
   end

   // Datapath array is not readable from here; A/B and busy-time C reads return 0.
   always_comb begin
      rdData = '0;
      if (statusHit)     rdData[0] = busy;
      else if (perfHit)  rdData = DATAW'(perfVal);
      else if (cHit && !busy) begin
         for (int w = 0; w < CW; w++)
            if (cSel == ADDRW'(w)) rdData = coutPad[w*DATAW +: DATAW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (wrReq && cmdHit) begin
               state <= dataIn[0] ? CLEAR : MUL;
               cnt   <= '0;
            end
            CLEAR: if (cnt == CNTW'(DIM-1)) begin
               state <= MUL;
               cnt   <= '0;
            end else cnt <= cnt + 1'b1;
            MUL: if (cnt == CNTW'(MULN-1)) begin
               state <= IDLE;
               cnt   <= '0;
            end else cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the shadow row is reset on purpose so a half-written C row never survives reset.
      if (!rst_n) begin
         dataOut <= '0;
         cBuf    <= '0;
      end else begin
         if (rdReq) dataOut <= rdData;
         if (wrReq && cHit && !cLast) begin
            for (int w = 0; w < CW-1; w++)
               if (cSel == ADDRW'(w)) cBuf[w*DATAW +: DATAW] <= dataIn;
         end
      end
   end

`ifdef TPU_PERF_CNT_EN
   logic [31:0] perf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          perf <= '0;
      else if (state == MUL && perf != '1) perf <= perf + 1'b1;
   end

   assign perfVal = perf;
`else
   assign perfVal = '0;
`endif

endmodule
